// File: rtl/cla_addsub_pipe_pkg.sv
// Shared constants and types for the pipelined carry-lookahead adder/subtractor.
// The per-stage record lives in the top because its field widths follow WIDTH/TAGW.
package cla_addsub_pipe_pkg;

  localparam int SLICE = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Operand sign bits carried to the last stage for the overflow decision.
  typedef struct packed {
    logic a;
    logic b;
  } sign_t;

endpackage

// File: rtl/cla_addsub_pipe_cla4.sv
// 4-bit carry-lookahead slice: all internal carries computed in parallel from
// generate/propagate terms, so the slice delay is independent of carry position.
module cla_addsub_pipe_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/cla_addsub_pipe.sv
// WIDTH-bit add/subtract pipeline, one 4-bit CLA slice per stage with the carry
// registered between stages; valid/ready on both sides, tag rides along.
module cla_addsub_pipe
  import cla_addsub_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAGW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [TAGW-1:0]  out_tag
);

  localparam int NSTG = WIDTH / SLICE;

  if ((WIDTH % SLICE) != 0 || WIDTH < SLICE) begin : g_width_check
    $error("cla_addsub_pipe: WIDTH must be a non-zero multiple of 4");
  end

  // Operands shift right by one slice per stage so the live nibble is always
  // at [3:0]; result nibbles shift in from the top and land in order at the end.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a_hi;
    logic [WIDTH-1:0] b_hi;
    logic [WIDTH-1:0] res_lo;
    logic             carry;
    sign_t            sgn;
    logic [TAGW-1:0]  tag;
  } stage_t;

  op_e              op;
  logic [WIDTH-1:0] b_cond;
  logic             c0;

  stage_t           st  [NSTG];
  stage_t           src [NSTG];
  logic [NSTG:0]    load;
  logic [SLICE-1:0] sum [NSTG];
  logic [NSTG-1:0]  cout;

  assign op     = op_e'(in_sub);
  assign b_cond = (op == OP_SUB) ? ~in_b : in_b;
  assign c0     = (op == OP_SUB) ? 1'b1 : in_cin;

  always_comb begin
    src[0].valid  = in_valid;
    src[0].a_hi   = in_a;
    src[0].b_hi   = b_cond;
    src[0].res_lo = '0;
    src[0].carry  = c0;
    src[0].sgn.a  = in_a[WIDTH-1];
    src[0].sgn.b  = b_cond[WIDTH-1];
    src[0].tag    = in_tag;
    for (int k = 1; k < NSTG; k++) begin
      src[k] = st[k-1];
    end
  end

  // A stage may load when it is empty or its contents move on this cycle, so
  // ready ripples back from out_ready and bubbles are squeezed out.
  always_comb begin
    load[NSTG] = out_ready;
    for (int k = NSTG - 1; k >= 0; k--) begin
      load[k] = ~st[k].valid | load[k+1];
    end
  end

  for (genvar k = 0; k < NSTG; k++) begin : g_stage
    cla_addsub_pipe_cla4 u_cla (
      .a   (src[k].a_hi[SLICE-1:0]),
      .b   (src[k].b_hi[SLICE-1:0]),
      .cin (src[k].carry),
      .sum (sum[k]),
      .cout(cout[k])
    );
  end

  // NOTE: the data fields are reset along with the valid bits, not just valid,
  // because out_res/out_cout/out_ovf/out_tag must read 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSTG; k++) begin
        st[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NSTG; k++) begin
        if (load[k]) begin
          st[k].valid  <= src[k].valid;
          st[k].a_hi   <= src[k].a_hi >> SLICE;
          st[k].b_hi   <= src[k].b_hi >> SLICE;
          st[k].res_lo <= (src[k].res_lo >> SLICE) | (WIDTH'(sum[k]) << (WIDTH - SLICE));
          st[k].carry  <= cout[k];
          st[k].sgn    <= src[k].sgn;
          st[k].tag    <= src[k].tag;
        end
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = st[NSTG-1].valid;
  assign out_res   = st[NSTG-1].res_lo;
  assign out_cout  = st[NSTG-1].carry;
  assign out_tag   = st[NSTG-1].tag;
  assign out_ovf   = (st[NSTG-1].sgn.a == st[NSTG-1].sgn.b)
                   & (st[NSTG-1].res_lo[WIDTH-1] != st[NSTG-1].sgn.a);
  assign out_zero  = (out_res == '0);

endmodule
